// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the serial subtractor
package serial_sub_pkg;
    localparam int DEF_WIDTH = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle between a requester and the serial subtractor
interface serial_subtractor_if import serial_sub_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_bout;
    modport master (output i_start, i_a, i_b, i_bin, input o_busy, o_done, o_diff, o_bout);
    modport slave  (input i_start, i_a, i_b, i_bin, output o_busy, o_done, o_diff, o_bout);
endinterface

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational subtract stage with borrow
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);
    assign o_diff = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin, one bit per clock
module serial_subtractor import serial_sub_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr;
    logic [CW-1:0]    cnt;
    logic             borrow, d_bit, b_bit, last;
    full_subtractor u_fs (
        .i_a    (a_sr[0]),
        .i_b    (b_sr[0]),
        .i_bin  (borrow),
        .o_diff (d_bit),
        .o_bout (b_bit)
    );
    assign last = cnt == CW'(WIDTH - 1);
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end
    always_comb begin
        state_nx   = IDLE;
        bus.o_busy = state != IDLE;
        bus.o_done = state == DONE;
        case (state)
            IDLE:    state_nx = bus.i_start ? CALC : IDLE;
            CALC:    state_nx = last ? DONE : CALC;
            default: state_nx = IDLE;
        endcase
    end
    // the result registers are written only on the final bit so partial sums never show
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            d_sr       <= '0;
            cnt        <= '0;
            borrow     <= 1'b0;
            bus.o_diff <= '0;
            bus.o_bout <= 1'b0;
        end else if (state == IDLE && bus.i_start) begin
            a_sr   <= bus.i_a;
            b_sr   <= bus.i_b;
            d_sr   <= '0;
            cnt    <= '0;
            borrow <= bus.i_bin;
        end else if (state == CALC) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            d_sr   <= {d_bit, d_sr[WIDTH-1:1]};
            cnt    <= cnt + 1'b1;
            borrow <= b_bit;
            if (last) begin
                bus.o_diff <= {d_bit, d_sr[WIDTH-1:1]};
                bus.o_bout <= b_bit;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench comparing every o_done result against plain arithmetic
module tb_serial_subtractor;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    serial_subtractor_if #(.WIDTH(W)) bus ();
    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );
    always #5 clk = ~clk;
    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    bit have_last = 0;
    bit bb_mode = 0;
    logic [W:0] exp_q[$];
    logic [W-1:0] held_diff = '0;
    logic held_bout = 1'b0;
    always @(posedge clk) cyc++;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask
    function automatic logic [W:0] model(input int a, input int b, input int bin);
        int r;
        r = a - b - bin;
        return {a < b + bin, W'(r & ((1 << W) - 1))};
    endfunction
    always @(negedge clk) begin
        logic [W:0] e;
        if (bus.o_done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("diff", 32'(bus.o_diff), 32'(e[W-1:0]));
                chk("bout", 32'(bus.o_bout), 32'(e[W]));
            end
            if (bb_mode && have_last) chk("done_spacing", cyc - last_done_cyc, W + 2);
            last_done_cyc = cyc;
            have_last = 1;
        end
    end
    task automatic op(input int a, input int b, input int bin, input bit disturb, input bit now);
        int n;
        bit stable;
        logic [W:0] e;
        if (!now) @(negedge clk);
        bus.i_a = W'(a);
        bus.i_b = W'(b);
        bus.i_bin = bin[0];
        bus.i_start = 1'b1;
        e = model(a, b, bin);
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        n = 0;
        stable = 1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.o_done) break;
            if (bus.o_diff !== held_diff || bus.o_bout !== held_bout) stable = 0;
            if (disturb && n == 2) begin
                bus.i_a = W'($urandom);
                bus.i_b = W'($urandom);
                bus.i_bin = 1'($urandom);
                bus.i_start = 1'b1;
            end
            if (n == 3) bus.i_start = 1'b0;
        end
        chk("latency", n, W + 1);
        chk("no_partial", 32'(stable), 1);
        held_diff = e[W-1:0];
        held_bout = e[W];
        @(negedge clk);
        chk("busy_after", 32'(bus.o_busy), 0);
    endtask
    initial begin
        int n;
        bus.i_start = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_done", 32'(bus.o_done), 0);
        chk("rst_diff", 32'(bus.o_diff), 0);
        chk("rst_bout", 32'(bus.o_bout), 0);
        rst_n = 1'b1;
        op(9, 3, 0, 0, 1);
        op(3, 9, 0, 0, 0);
        op(0, 0, 1, 0, 0);
        op(15, 15, 1, 0, 0);
        op(7, 2, 1, 1, 0);
        op(15, 0, 0, 0, 0);
        // abort an operation with reset at its second calc edge
        @(negedge clk);
        bus.i_a = 4'd12;
        bus.i_b = 4'd5;
        bus.i_bin = 1'b0;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.o_busy), 0);
        chk("abort_done", 32'(bus.o_done), 0);
        chk("abort_diff", 32'(bus.o_diff), 0);
        chk("abort_bout", 32'(bus.o_bout), 0);
        held_diff = '0;
        held_bout = 1'b0;
        rst_n = 1'b1;
        op(6, 11, 1, 0, 1);
        repeat (20) op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 1)), 1'($urandom), 0);
        // exhaustive sweep with start held high: accepts every W+2 cycles
        @(negedge clk);
        bb_mode = 1;
        have_last = 0;
        bus.i_start = 1'b1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    bus.i_a = W'(a);
                    bus.i_b = W'(b);
                    bus.i_bin = c[0];
                    exp_q.push_back(model(a, b, c));
                    repeat (W + 2) @(negedge clk);
                end
        bus.i_start = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        bb_mode = 0;
        repeat (10) @(negedge clk);
        chk("idle_end", 32'(bus.o_busy), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
